// File: rtl/prio_enc_seg_pkg.sv
// ----------------------------------------------------------------------------
// prio_pkg : shared seven-segment constants for prio_enc_seg   | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package prio_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam int SEG_A  = 0;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Active-low segments g..a for hex digits 0..F
   localparam logic [0:15][6:0] HEX_SEG = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

`default_nettype wire

// File: rtl/prio_enc_seg_if.sv
// ----------------------------------------------------------------------------
// prio_enc_seg_if : switch inputs and encoder/display outputs   | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface prio_enc_seg_if #(
   parameter int N_IN = 16
);
   logic [N_IN-1:0]          in_raw;
   logic                     mode_hold;
   logic                     clr;
   logic [$clog2(N_IN)-1:0]  idx;
   logic                     valid;
   logic                     held;
   logic                     chg;
   logic [7:0]               seg0;
   logic [7:0]               seg1;

   modport master (
      output in_raw, mode_hold, clr,
      input  idx, valid, held, chg, seg0, seg1
   );

   modport slave (
      input  in_raw, mode_hold, clr,
      output idx, valid, held, chg, seg0, seg1
   );
endinterface

`default_nettype wire

// File: rtl/prio_enc_seg_hex7seg.sv
// ----------------------------------------------------------------------------
// hex7seg : nibble to active-low seven-segment pattern with blank/dp  | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hex7seg
   import prio_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   input  logic       dp,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         seg[SEG_G:SEG_A] = HEX_SEG[nibble];
         seg[SEG_DP]      = ~dp;
      end
   end

endmodule

`default_nettype wire

// File: rtl/prio_enc_seg.sv
// ----------------------------------------------------------------------------
// prio_enc_seg : sync + debounce + priority encoder + hex display, Rev 1.0
// Optional debounce filter enabled by PRIO_DEBOUNCE_EN (bypassed otherwise).
// ----------------------------------------------------------------------------
`default_nettype none

module prio_enc_seg
   import prio_pkg::*;
#(
   parameter int N_IN      = 16,
   parameter int DB_CYCLES = 4
)(
   input  logic          clk,
   input  logic          rst,
   prio_enc_seg_if.slave bus
);

   localparam int IDX_W = $clog2(N_IN);

   generate
      if (N_IN < 2 || N_IN > 256) begin : g_bad_n_in
         $error("prio_enc_seg: N_IN must be in 2..256");
      end
      if (DB_CYCLES < 1) begin : g_bad_db_cycles
         $error("prio_enc_seg: DB_CYCLES must be >= 1");
      end
   endgenerate

   logic [N_IN-1:0] sync1;
   logic [N_IN-1:0] sync2;
   logic [N_IN-1:0] stable;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.in_raw;
         sync2 <= sync1;
      end
   end

`ifdef PRIO_DEBOUNCE_EN
   localparam int              CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [N_IN-1:0]  cand;
   logic [CNT_W-1:0] cnt;

   // One counter for the whole vector: any bit change restarts the window.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand   <= '0;
         cnt    <= '0;
         stable <= '0;
      end else if (sync2 != cand) begin
         cand <= sync2;
         cnt  <= '0;
      end else if (cnt == CNT_LAST) begin
         stable <= cand;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   assign stable = sync2;
`endif

   logic [IDX_W-1:0] msb_idx;

   always_comb begin
      msb_idx = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (stable[i]) begin
            msb_idx = IDX_W'(i);
         end
      end
   end

   logic [IDX_W-1:0] enc_idx;
   logic             enc_valid;
   logic             enc_held;
   logic             chg_pulse;
   logic [IDX_W-1:0] idx_d;
   logic             valid_d;
   logic             held_d;

   // A retained index exists only if something was shown last cycle; clr and
   // live mode both drop it, but a non-zero vector always wins.
   always_comb begin
      idx_d   = '0;
      valid_d = 1'b0;
      held_d  = 1'b0;
      if (stable != '0) begin
         idx_d   = msb_idx;
         valid_d = 1'b1;
      end else if (bus.mode_hold && !bus.clr && (enc_valid || enc_held)) begin
         idx_d  = enc_idx;
         held_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         enc_idx   <= '0;
         enc_valid <= 1'b0;
         enc_held  <= 1'b0;
         chg_pulse <= 1'b0;
      end else begin
         enc_idx   <= idx_d;
         enc_valid <= valid_d;
         enc_held  <= held_d;
         chg_pulse <= {idx_d, valid_d, held_d} != {enc_idx, enc_valid, enc_held};
      end
   end

   logic [7:0] idx_ext;
   logic       blank;
   logic [7:0] seg_lo;
   logic [7:0] seg_hi;

   always_comb begin
      idx_ext              = '0;
      idx_ext[IDX_W-1:0]   = enc_idx;
   end

   assign blank = !enc_valid && !enc_held;

   hex7seg u_seg_lo (
      .nibble (idx_ext[3:0]),
      .blank  (blank),
      .dp     (enc_held),
      .seg    (seg_lo)
   );

   hex7seg u_seg_hi (
      .nibble (idx_ext[7:4]),
      .blank  (blank),
      .dp     (1'b0),
      .seg    (seg_hi)
   );

   assign bus.idx   = enc_idx;
   assign bus.valid = enc_valid;
   assign bus.held  = enc_held;
   assign bus.chg   = chg_pulse;
   assign bus.seg0  = seg_lo;
   assign bus.seg1  = seg_hi;

endmodule

`default_nettype wire

// File: tb/tb_prio_enc_seg.sv
// ----------------------------------------------------------------------------
// tb_prio_enc_seg : directed + randomized bench against a behavioural model
// ----------------------------------------------------------------------------
`default_nettype none

module tb_prio_enc_seg;

   localparam int N_IN = 16;
   localparam int DB   = 4;
`ifdef PRIO_DEBOUNCE_EN
   localparam int LAT  = DB + 4;
`else
   localparam int LAT  = 3;
`endif

   localparam logic [7:0] HEX [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   prio_enc_seg_if #(.N_IN(N_IN)) bus ();

   prio_enc_seg #(.N_IN(N_IN), .DB_CYCLES(DB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] cur_in;
   logic        cur_mh;
   logic        cur_clr;

   // Reference state: raw samples seen at each edge, and the visible outputs
   logic [15:0] hist[$];
   logic [15:0] m_stable;
   logic [3:0]  m_idx;
   logic        m_valid;
   logic        m_held;
   logic        m_chg;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      repeat (32) hist.push_back(16'h0000);
      m_stable = '0;
      m_idx    = '0;
      m_valid  = 1'b0;
      m_held   = 1'b0;
      m_chg    = 1'b0;
   endtask

   task automatic model_edge();
      logic [3:0] pi;
      logic       pv, ph;
      int         hb;
      int         n;
      bit         same;
      hist.push_back(cur_in);
      if (hist.size() > 32) void'(hist.pop_front());
      pi = m_idx; pv = m_valid; ph = m_held;
      if (m_stable != 0) begin
         hb      = $clog2({16'h0000, m_stable} + 32'd1) - 1;
         m_idx   = hb[3:0];
         m_valid = 1'b1;
         m_held  = 1'b0;
      end else begin
         m_valid = 1'b0;
         if (cur_clr || !cur_mh || !(pv || ph)) begin
            m_idx  = '0;
            m_held = 1'b0;
         end else begin
            m_held = 1'b1;
         end
      end
      m_chg = ({m_idx, m_valid, m_held} != {pi, pv, ph});
      n = hist.size();
`ifdef PRIO_DEBOUNCE_EN
      // Commit the synchronised value once it has been seen DB+1 times in a row
      same = 1'b1;
      for (int j = 0; j <= DB; j++) begin
         if (hist[n-3-j] != hist[n-3]) same = 1'b0;
      end
      if (same) m_stable = hist[n-3];
`else
      same = 1'b1;
      m_stable = hist[n-2];
`endif
   endtask

   task automatic check_all();
      logic       blank;
      logic [7:0] e0, e1;
      blank = !m_valid && !m_held;
      e0 = blank ? 8'hFF : (HEX[m_idx] & (m_held ? 8'h7F : 8'hFF));
      e1 = blank ? 8'hFF : HEX[0];
      chk("idx",   bus.idx,   m_idx);
      chk("valid", bus.valid, m_valid);
      chk("held",  bus.held,  m_held);
      chk("chg",   bus.chg,   m_chg);
      chk("seg0",  bus.seg0,  e0);
      chk("seg1",  bus.seg1,  e1);
   endtask

   // Called just after an edge; drives the next inputs and checks after the following edge
   task automatic step(input logic [15:0] v, input logic mh, input logic c);
      cur_in = v; cur_mh = mh; cur_clr = c;
      bus.in_raw = v; bus.mode_hold = mh; bus.clr = c;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic run(input logic [15:0] v, input logic mh, input int n);
      for (int i = 0; i < n; i++) step(v, mh, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_raw = '0; bus.mode_hold = 1'b0; bus.clr = 1'b0;
      cur_in = '0; cur_mh = 1'b0; cur_clr = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("rst_seg0", bus.seg0, 8'hFF);
      #1 rst = 1'b1;

      // Encode latency and basic patterns
      run(16'h0001, 1'b0, LAT - 1);
      chk("lat_pre_valid", bus.valid, 1'b0);
      step(16'h0001, 1'b0, 1'b0);
      chk("lat_valid", bus.valid, 1'b1);
      chk("lat_chg",   bus.chg,   1'b1);
      chk("lat_seg0",  bus.seg0,  8'hC0);
      run(16'h0001, 1'b0, 3);
      run(16'h8421, 1'b0, LAT + 1);
      chk("msb15_idx",  bus.idx,  15);
      chk("msb15_seg0", bus.seg0, 8'h8E);
      chk("msb15_seg1", bus.seg1, 8'hC0);

      // Glitch on bit 3: short pulse, then long pulse
      run(16'h0001, 1'b0, LAT + 2);
      run(16'h0009, 1'b0, 2);
      run(16'h0001, 1'b0, LAT + 2);
      run(16'h0009, 1'b0, LAT + 2);
      chk("glitch_long_idx", bus.idx, 3);

      // Hold mode, then clr
      run(16'h0040, 1'b1, LAT + 1);
      chk("hold_seg0_live", bus.seg0, 8'h82);
      run(16'h0000, 1'b1, LAT + 1);
      chk("hold_held", bus.held, 1'b1);
      chk("hold_idx",  bus.idx,  6);
      chk("hold_seg0", bus.seg0, 8'h02);
      step(16'h0000, 1'b1, 1'b1);
      chk("clr_seg0", bus.seg0, 8'hFF);
      chk("clr_chg",  bus.chg,  1'b1);
      run(16'h0000, 1'b1, 2);

      // Live zero
      run(16'h0040, 1'b0, LAT + 1);
      run(16'h0000, 1'b0, LAT + 1);
      chk("live_zero_seg1", bus.seg1, 8'hFF);

      // clr on the committing edge is ignored
      run(16'h0100, 1'b0, LAT - 1);
      step(16'h0100, 1'b0, 1'b1);
      chk("clr_prec_idx",   bus.idx,   8);
      chk("clr_prec_valid", bus.valid, 1'b1);

      // mode_hold falling while held
      run(16'h0200, 1'b1, LAT + 1);
      run(16'h0000, 1'b1, LAT + 1);
      step(16'h0000, 1'b0, 1'b0);
      chk("mh_fall_held", bus.held, 1'b0);

      // Randomized bursts
      begin
         logic [15:0] v;
         logic        mh;
         int          len;
         mh = 1'b0;
         for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
               0:       v = 16'h0000;
               1:       v = 16'h0001 << $urandom_range(0, 15);
               default: v = 16'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) mh = ~mh;
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) step(v, mh, ($urandom_range(0, 9) == 0));
         end
      end

      // Asynchronous reset mid-cycle while showing index 5
      run(16'h0020, 1'b0, LAT + 1);
      chk("pre_rst_idx", bus.idx, 5);
      #3 rst = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("arst_seg0", bus.seg0, 8'hFF);
      chk("arst_seg1", bus.seg1, 8'hFF);
      #1 rst = 1'b1;
      run(16'h0004, 1'b0, LAT + 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
